// File: rtl/vdf_sq_loop_ctrl.sv
// VDF squaring-loop controller: iterates an operand through an external squarer, then carry-normalises
// and conditionally subtracts MODULUS. Define VDF_SQ_LOOP_CYCLE_CNT_EN to add the o_cycles counter.
module vdf_sq_loop_ctrl #(
    parameter int WORD_BITS       = 35,
    parameter int NUM_WORDS       = 30,
    parameter logic [NUM_WORDS*WORD_BITS-1:0] MODULUS =
        {26'd0, 1'b1, {15{64'h9E37_79B9_7F4A_7C15}}, 63'h3C6E_F372_FE94_F82B},
    parameter int REDUN_WORD_BITS = 1,
    parameter int I_WORD          = NUM_WORDS + 1,
    parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
    parameter int ITER_BITS       = 40
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [ITER_BITS-1:0]            i_iter,
    input  logic [I_WORD*COEF_BITS-1:0]     i_dat,
    output logic                            o_busy,
    output logic                            o_val,
    output logic [NUM_WORDS*WORD_BITS-1:0]  o_dat,
    output logic                            o_sq_val,
    output logic                            o_sq_reduce_only,
    output logic [I_WORD*COEF_BITS-1:0]     o_sq_dat,
    input  logic                            i_sq_val,
    input  logic [I_WORD*COEF_BITS-1:0]     i_sq_dat
`ifdef VDF_SQ_LOOP_CYCLE_CNT_EN
    ,
    output logic [63:0]                     o_cycles
`endif
);

    localparam int OW = NUM_WORDS * WORD_BITS;
    localparam int DW = I_WORD * COEF_BITS;
    localparam int KW = $clog2(I_WORD + 1);
    localparam int CW = REDUN_WORD_BITS + 1;
    localparam logic [I_WORD*WORD_BITS-1:0] MOD_EXT = {{WORD_BITS{1'b0}}, MODULUS};

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_RED_ISSUE, S_RED_WAIT, S_NORM, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        op_q, op_d;
    logic [ITER_BITS-1:0] iter_q, iter_d;
    logic [KW-1:0]        k_q, k_d;
    logic [CW-1:0]        carry_q, carry_d;
    logic                 borrow_q, borrow_d;
    logic [OW-1:0]        norm_q, norm_d;
    logic [OW-1:0]        diff_q, diff_d;
    logic [OW-1:0]        dat_q, dat_d;

    logic [COEF_BITS:0]   sum_w;
    logic [WORD_BITS-1:0] norm_word;
    logic [WORD_BITS-1:0] mod_word;
    logic [WORD_BITS:0]   diff_w;

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        iter_d           = iter_q;
        k_d              = k_q;
        carry_d          = carry_q;
        borrow_d         = borrow_q;
        norm_d           = norm_q;
        diff_d           = diff_q;
        dat_d            = dat_q;
        o_busy           = (state_q != S_IDLE);
        o_val            = 1'b0;
        o_sq_val         = 1'b0;
        o_sq_reduce_only = 1'b0;

        // One normalise/subtract step on the lowest remaining coefficient of op_q.
        sum_w     = {1'b0, op_q[COEF_BITS-1:0]} + {{(COEF_BITS + 1 - CW){1'b0}}, carry_q};
        norm_word = sum_w[WORD_BITS-1:0];
        mod_word  = MOD_EXT[k_q*WORD_BITS +: WORD_BITS];
        diff_w    = {1'b0, norm_word} - {1'b0, mod_word} - {{WORD_BITS{1'b0}}, borrow_q};

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    op_d     = i_dat;
                    iter_d   = i_iter;
                    k_d      = '0;
                    carry_d  = '0;
                    borrow_d = 1'b0;
                    state_d  = (i_iter != '0) ? S_ISSUE : S_RED_ISSUE;
                end
            end
            S_ISSUE: begin
                o_sq_val = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (i_sq_val) begin
                    op_d    = i_sq_dat;
                    iter_d  = iter_q - ITER_BITS'(1);
                    state_d = (iter_q == ITER_BITS'(1)) ? S_RED_ISSUE : S_ISSUE;
                end
            end
            S_RED_ISSUE: begin
                o_sq_val         = 1'b1;
                o_sq_reduce_only = 1'b1;
                state_d          = S_RED_WAIT;
            end
            S_RED_WAIT: begin
                if (i_sq_val) begin
                    op_d    = i_sq_dat;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                op_d     = op_q >> COEF_BITS;
                carry_d  = sum_w[COEF_BITS:WORD_BITS];
                borrow_d = diff_w[WORD_BITS];
                k_d      = k_q + KW'(1);
                if (k_q < KW'(NUM_WORDS)) begin
                    norm_d = {norm_word, norm_q[OW-1:WORD_BITS]};
                    diff_d = {diff_w[WORD_BITS-1:0], diff_q[OW-1:WORD_BITS]};
                end
                // A leftover carry means the value exceeds any modulus, so it cancels the borrow.
                if (k_q == KW'(I_WORD - 1)) begin
                    borrow_d = diff_w[WORD_BITS] & (carry_d == '0);
                    dat_d    = borrow_d ? norm_d : diff_d;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                o_val   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            iter_q   <= '0;
            k_q      <= '0;
            carry_q  <= '0;
            borrow_q <= 1'b0;
            norm_q   <= '0;
            diff_q   <= '0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            iter_q   <= iter_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            norm_q   <= norm_d;
            diff_q   <= diff_d;
            dat_q    <= dat_d;
        end
    end

    assign o_dat    = dat_q;
    assign o_sq_dat = op_q;

`ifdef VDF_SQ_LOOP_CYCLE_CNT_EN
    // Preloaded with 2 so the start cycle and first busy cycle are both included at o_val.
    logic [63:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE && i_start) begin
            cyc_d = 64'd2;
        end else if (state_q != S_IDLE && state_q != S_DONE) begin
            cyc_d = cyc_q + 64'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign o_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_vdf_sq_loop_ctrl.sv
// Directed bench for vdf_sq_loop_ctrl with a behavioural squarer (x^2 mod M, or x mod M on reduce passes).
module tb_vdf_sq_loop_ctrl;

    localparam int WB  = 35;
    localparam int NW  = 30;
    localparam int IW  = NW + 1;
    localparam int CB  = WB + 1;
    localparam int ITB = 40;
    localparam int OW  = NW * WB;
    localparam int DW  = IW * CB;
    localparam int BW  = 2240;
    localparam logic [OW-1:0] M =
        {26'd0, 1'b1, {15{64'h9E37_79B9_7F4A_7C15}}, 63'h3C6E_F372_FE94_F82B};

    logic           clk;
    logic           rst;
    logic           start;
    logic [ITB-1:0] iter;
    logic [DW-1:0]  dat;
    logic           busy;
    logic           val;
    logic [OW-1:0]  odat;
    logic           sqVal;
    logic           sqRed;
    logic [DW-1:0]  sqDat;
    logic           sqValIn;
    logic [DW-1:0]  sqDatIn;
`ifdef VDF_SQ_LOOP_CYCLE_CNT_EN
    logic [63:0]    cycles;
`endif

    int            vectors = 0;
    int            miscompares = 0;
    int            lat = 1;
    bit            ovrEn = 0;
    logic [BW-1:0] ovrVal = '0;
    int            sqIssues = 0;
    int            redIssues = 0;

    vdf_sq_loop_ctrl #(.MODULUS(M)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_iter           (iter),
        .i_dat            (dat),
        .o_busy           (busy),
        .o_val            (val),
        .o_dat            (odat),
        .o_sq_val         (sqVal),
        .o_sq_reduce_only (sqRed),
        .o_sq_dat         (sqDat),
        .i_sq_val         (sqValIn),
        .i_sq_dat         (sqDatIn)
`ifdef VDF_SQ_LOOP_CYCLE_CNT_EN
        ,
        .o_cycles         (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] toInt(input logic [DW-1:0] v);
        logic [BW-1:0] acc;
        acc = '0;
        for (int k = IW - 1; k >= 0; k--) acc = (acc << WB) + BW'(v[k*CB +: CB]);
        return acc;
    endfunction

    // Encodes an integer with most coefficients pushed above 2^WB so the DUT must ripple carries.
    function automatic logic [DW-1:0] toRed(input logic [BW-1:0] x);
        logic [CB-1:0] w [IW];
        logic [DW-1:0] r;
        for (int k = 0; k < IW; k++) w[k] = {1'b0, x[k*WB +: WB]};
        for (int k = 0; k < IW - 1; k++) begin
            if (w[k+1] != '0) begin
                w[k+1] = w[k+1] - CB'(1);
                w[k]   = w[k] + (CB'(1) << WB);
            end
        end
        r = '0;
        for (int k = 0; k < IW; k++) r[k*CB +: CB] = w[k];
        return r;
    endfunction

    initial begin
        logic [BW-1:0] x;
        logic [BW-1:0] r;
        sqValIn = 1'b0;
        sqDatIn = '0;
        @(posedge clk); #1;
        forever begin
            if (!sqVal) begin
                @(posedge clk); #1;
            end else begin
                x = toInt(sqDat);
                if (sqRed) begin
                    redIssues++;
                    r = ovrEn ? ovrVal : x % BW'(M);
                end else begin
                    sqIssues++;
                    r = (x * x) % BW'(M);
                end
                repeat (lat) @(posedge clk);
                #1;
                sqValIn = 1'b1;
                sqDatIn = toRed(r);
                @(posedge clk); #1;
                sqValIn = 1'b0;
            end
        end
    end

    task automatic runOp(input logic [ITB-1:0] it, input logic [DW-1:0] d,
                         output logic [OW-1:0] res, output int cyc);
        int  n;
        bit  seen;
        @(posedge clk); #1;
        iter  = it;
        dat   = d;
        start = 1'b1;
        n     = 1;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 0;
        res   = '0;
        cyc   = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            n++;
            if (val) begin
                seen = 1;
                res  = odat;
                cyc  = n;
            end else begin
                @(posedge clk); #1;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL run_timeout got no o_val, required o_val within 3000 cycles");
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        iter  = '0;
        dat   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors += 6;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (val !== 1'b0) begin miscompares++; $display("FAIL reset_val got=%b exp=0", val); end
        if (sqVal !== 1'b0) begin miscompares++; $display("FAIL reset_sq_val got=%b exp=0", sqVal); end
        if (sqRed !== 1'b0) begin miscompares++; $display("FAIL reset_sq_red got=%b exp=0", sqRed); end
        if (odat !== '0) begin miscompares++; $display("FAIL reset_o_dat got=%0h exp=0", odat); end
        if (sqDat !== '0) begin miscompares++; $display("FAIL reset_sq_dat got=%0h exp=0", sqDat); end
`ifdef VDF_SQ_LOOP_CYCLE_CNT_EN
        vectors++;
        if (cycles !== 64'd0) begin miscompares++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
`endif
    endtask

    task automatic test_zero_iter();
        logic [OW-1:0] res;
        logic [DW-1:0] d;
        int cyc;
        lat = 3; ovrEn = 0; sqIssues = 0; redIssues = 0;
        d = '0;
        d[CB-1:0] = CB'(5);
        runOp('0, d, res, cyc);
        vectors += 4;
        if (res !== OW'(5)) begin miscompares++; $display("FAIL zero_iter_dat got=%0h exp=5", res); end
        if (sqIssues !== 0) begin miscompares++; $display("FAIL zero_iter_sq_issues got=%0d exp=0", sqIssues); end
        if (redIssues !== 1) begin miscompares++; $display("FAIL zero_iter_red_issues got=%0d exp=1", redIssues); end
        if (cyc !== 37) begin miscompares++; $display("FAIL zero_iter_latency got=%0d exp=37", cyc); end
    endtask

    task automatic test_iterations();
        logic [OW-1:0] res;
        logic [DW-1:0] d;
        int cyc;
        lat = 1; ovrEn = 0; sqIssues = 0; redIssues = 0;
        d = '0;
        d[CB-1:0] = CB'(2);
        runOp(ITB'(3), d, res, cyc);
        vectors += 4;
        if (res !== OW'(256)) begin miscompares++; $display("FAIL iter3_dat got=%0h exp=100", res); end
        if (sqIssues !== 3) begin miscompares++; $display("FAIL iter3_sq_issues got=%0d exp=3", sqIssues); end
        if (redIssues !== 1) begin miscompares++; $display("FAIL iter3_red_issues got=%0d exp=1", redIssues); end
        if (cyc !== 41) begin miscompares++; $display("FAIL iter3_latency got=%0d exp=41", cyc); end
`ifdef VDF_SQ_LOOP_CYCLE_CNT_EN
        vectors++;
        if (cycles !== 64'd41) begin miscompares++; $display("FAIL iter3_cycles got=%0d exp=41", cycles); end
`endif
    endtask

    task automatic test_final_subtract();
        logic [OW-1:0] res;
        logic [DW-1:0] d;
        int cyc;
        lat = 5; ovrEn = 1;
        d = '0;
        d[CB-1:0] = CB'(5);
        ovrVal = BW'(M) + BW'(7);
        runOp('0, d, res, cyc);
        vectors++;
        if (res !== OW'(7)) begin miscompares++; $display("FAIL sub_m_plus_7 got=%0h exp=7", res); end
        ovrVal = BW'(M) - BW'(1);
        runOp('0, d, res, cyc);
        vectors++;
        if (res !== M - OW'(1)) begin miscompares++; $display("FAIL sub_m_minus_1 got=%0h exp=%0h", res, M - OW'(1)); end
        ovrEn = 0;
    endtask

    task automatic test_redundant_input();
        logic [OW-1:0] res;
        logic [DW-1:0] d;
        logic [BW-1:0] expect_v;
        int cyc;
        lat = 2; ovrEn = 0;
        d = '0;
        expect_v = '0;
        for (int k = 0; k < IW; k++) begin
            d[k*CB +: CB] = CB'(1) << WB;
            expect_v = expect_v + (BW'(1) << (WB * (k + 1)));
        end
        expect_v = expect_v % BW'(M);
        runOp('0, d, res, cyc);
        vectors += 2;
        if (res !== expect_v[OW-1:0]) begin miscompares++; $display("FAIL redundant_dat got=%0h exp=%0h", res, expect_v[OW-1:0]); end
        if (cyc !== 36) begin miscompares++; $display("FAIL redundant_latency got=%0d exp=36", cyc); end
    endtask

    task automatic test_reset_midop();
        logic [OW-1:0] res;
        logic [DW-1:0] d;
        int cyc;
        int nv;
        int nIss;
        lat = 10; ovrEn = 0;
        d = '0;
        d[CB-1:0] = CB'(2);
        @(posedge clk); #1;
        iter = ITB'(5); dat = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL midop_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nv = 0; nIss = 0;
        for (int i = 0; i < 40; i++) begin
            if (val) nv++;
            if (sqVal) nIss++;
            @(posedge clk); #1;
        end
        vectors += 3;
        if (nv !== 0) begin miscompares++; $display("FAIL midop_no_val got=%0d exp=0", nv); end
        if (nIss !== 0) begin miscompares++; $display("FAIL midop_no_issue got=%0d exp=0", nIss); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midop_idle got=%b exp=0", busy); end
        lat = 1;
        d[CB-1:0] = CB'(3);
        runOp(ITB'(1), d, res, cyc);
        vectors++;
        if (res !== OW'(9)) begin miscompares++; $display("FAIL midop_restart_dat got=%0h exp=9", res); end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] res;
        logic [DW-1:0] d;
        logic [DW-1:0] d7;
        int cyc;
        int nv;
        int n;
        lat = 2; ovrEn = 0;
        d = '0;
        d[CB-1:0] = CB'(3);
        d7 = '0;
        d7[CB-1:0] = CB'(7);
        res = '0; cyc = 0;
        @(posedge clk); #1;
        iter = ITB'(2); dat = d; start = 1'b1; n = 1;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0;
        for (int i = 0; i < 200; i++) begin
            n++;
            if (val) begin
                nv++;
                if (nv == 1) begin res = odat; cyc = n; end
            end
            if (i == 4 || i == 9) begin
                vectors++;
                if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_at_%0d got=%b exp=1", i, busy); end
                iter = '0; dat = d7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        vectors += 4;
        if (nv !== 1) begin miscompares++; $display("FAIL b2b_val_count got=%0d exp=1", nv); end
        if (res !== OW'(81)) begin miscompares++; $display("FAIL b2b_dat got=%0h exp=51", res); end
        if (cyc !== 42) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=42", cyc); end
        if (odat !== OW'(81)) begin miscompares++; $display("FAIL b2b_hold got=%0h exp=51", odat); end
`ifdef VDF_SQ_LOOP_CYCLE_CNT_EN
        vectors++;
        if (cycles !== 64'd42) begin miscompares++; $display("FAIL b2b_cycles got=%0d exp=42", cycles); end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_iter();
        test_iterations();
        test_final_subtract();
        test_redundant_input();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
